// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch stage
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam logic [INSTR_W-1:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - program memory and decoder-side signals of the fetch stage
interface inst_fetch_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               stall;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;

  modport master (
    output mem_req, mem_addr, instr, instr_valid,
    input  mem_ack, mem_rdata, stall
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_valid,
    output mem_ack, mem_rdata, stall
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC, byte fetch over req/ack, registered instruction with valid
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int                  ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
  parameter logic [INSTR_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted,
  inst_fetch_if.master      bus
);

  fetch_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic               r_valid, w_valid_nxt;
  logic               w_req, w_accept, w_consume, w_redirect;

  // Request is withheld while a held instruction is stalled, so acks then are ignored.
  assign w_req      = (r_state == FETCH) && !(r_valid && bus.stall) && !i_redirect;
  assign w_accept   = w_req && bus.mem_ack;
  assign w_consume  = r_valid && !bus.stall;
  assign w_redirect = i_redirect && (r_state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;

    case (r_state)
      IDLE:    if (i_en) w_state_nxt = FETCH;
      FETCH:   if (w_accept && (bus.mem_rdata == HALT_OPCODE)) w_state_nxt = HALTED;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase

    // Priority: redirect > accept > consume.
    if (w_redirect) begin
      w_state_nxt = FETCH;
      w_pc_nxt    = i_redirect_addr;
      w_valid_nxt = 1'b0;
    end else if (w_accept) begin
      w_instr_nxt = bus.mem_rdata;
      w_valid_nxt = 1'b1;
      w_pc_nxt    = r_pc + 1'b1;
    end else if (w_consume) begin
      w_valid_nxt = 1'b0;
    end
  end

  assign bus.mem_req     = w_req;
  assign bus.mem_addr    = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_valid;
  assign o_pc            = r_pc;
  assign o_halted        = (r_state == HALTED);

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       t_en = 1'b0;
  logic       t_redir = 1'b0;
  logic [7:0] t_raddr = 8'h00;
  logic [7:0] pc;
  logic       halted;
  logic [7:0] mem [256];

  int n_chk = 0;
  int n_err = 0;

  inst_fetch_if #(.ADDR_W(8)) bus ();

  inst_fetch #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_OPCODE(8'hFF)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_en            (t_en),
    .i_redirect      (t_redir),
    .i_redirect_addr (t_raddr),
    .o_pc            (pc),
    .o_halted        (halted),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct {
    logic       en, stall, ack, redir;
    logic [7:0] raddr;
    logic       req;
    logic [7:0] instr;
    logic       valid;
    logic [7:0] pc;
    logic       halt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic st, input logic ak,
                      input logic rd, input logic [7:0] ra);
    @(negedge clk);
    t_en        = en;
    bus.stall   = st;
    bus.mem_ack = ak;
    t_redir     = rd;
    t_raddr     = ra;
    #1;
  endtask

  // Reference model state for the randomized phase
  bit       m_run, m_halt, m_valid;
  bit [7:0] m_pc, m_instr;

  initial begin
    bus.stall   = 1'b0;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h08; mem[1] = 8'h09; mem[2] = 8'h01; mem[3] = 8'h41;
    mem[4] = 8'h22; mem[5] = 8'hFF;
    mem[8'h40] = 8'h5A; mem[8'h41] = 8'h33; mem[8'hFF] = 8'h11;

    //          en    stall ack   redir raddr   | req   instr  valid pc     halt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 8'h01, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h09, 1'b1, 8'h02, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h09, 1'b1, 8'h02, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h09, 1'b1, 8'h02, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h09, 1'b1, 8'h02, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h01, 1'b1, 8'h03, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h40, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h41, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h41, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h41, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 8'h42, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset.req", bus.mem_req, 0);
    chk("reset.valid", bus.instr_valid, 0);
    chk("reset.instr", bus.instr, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].en, vecs[i].stall, vecs[i].ack, vecs[i].redir, vecs[i].raddr);
      chk($sformatf("v%0d.req", i),   bus.mem_req,     vecs[i].req);
      chk($sformatf("v%0d.addr", i),  bus.mem_addr,    vecs[i].pc);
      chk($sformatf("v%0d.instr", i), bus.instr,       vecs[i].instr);
      chk($sformatf("v%0d.valid", i), bus.instr_valid, vecs[i].valid);
      chk($sformatf("v%0d.pc", i),    pc,              vecs[i].pc);
      chk($sformatf("v%0d.halt", i),  halted,          vecs[i].halt);
    end

    // Halt on FF fetched from address 5, then recovery by redirect
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("halt.addr4", bus.mem_addr, 8'h04);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("halt.instr22", bus.instr, 8'h22);
    chk("halt.addr5", bus.mem_addr, 8'h05);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("halt.instrFF", bus.instr, 8'hFF);
    chk("halt.validFF", bus.instr_valid, 1);
    chk("halt.halted", halted, 1);
    chk("halt.pc", pc, 8'h06);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("halt.req%0d", i), bus.mem_req, 0);
      chk($sformatf("halt.hold%0d", i), {halted, bus.instr_valid, pc}, {1'b1, 1'b0, 8'h06});
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("resume.halted", halted, 0);
    chk("resume.req", bus.mem_req, 1);
    chk("resume.addr", bus.mem_addr, 8'h00);

    // PC wrap from FF to 00
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap.addrFF", bus.mem_addr, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("wrap.addr00", bus.mem_addr, 8'h00);
    chk("wrap.instr", bus.instr, 8'h11);
    chk("wrap.valid", bus.instr_valid, 1);

    // Asynchronous reset while stalled with a valid instruction
    #2 rst_n = 1'b0;
    #1;
    chk("areset.valid", bus.instr_valid, 0);
    chk("areset.pc", pc, 8'h00);
    chk("areset.req", bus.mem_req, 0);
    chk("areset.instr", bus.instr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase against the behavioural model
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(31) == 0) ? 8'hFF : 8'($urandom);
    m_run = 0; m_halt = 0; m_valid = 0; m_pc = 8'h00; m_instr = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      bit en, st, ak, rd, req;
      bit [7:0] ra;
      en = ($urandom_range(3) == 0);
      st = ($urandom_range(3) == 0);
      ak = ($urandom_range(2) != 0);
      rd = m_halt ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      ra = 8'($urandom);
      step(en, st, ak, rd, ra);
      req = m_run && !m_halt && !(m_valid && st) && !rd;
      chk("rnd.req", bus.mem_req, req);
      chk("rnd.addr", bus.mem_addr, m_pc);
      chk("rnd.instr", bus.instr, m_instr);
      chk("rnd.valid", bus.instr_valid, m_valid);
      chk("rnd.pc", pc, m_pc);
      chk("rnd.halt", halted, m_halt);
      if (!m_run) begin
        if (en) m_run = 1;
      end else if (rd) begin
        m_pc = ra; m_valid = 0; m_halt = 0;
      end else if (req && ak) begin
        m_instr = mem[m_pc];
        m_valid = 1;
        if (mem[m_pc] == 8'hFF) m_halt = 1;
        m_pc = m_pc + 8'd1;
      end else if (m_valid && !st) begin
        m_valid = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage that sits directly upstream of inst_decoder.
- Holds the program counter, requests 8-bit instruction bytes from program memory with a req/ack handshake, and presents them to the decoder's 8-bit input through a registered instruction register with a valid flag.
- Supports decoder/back-end stall, PC redirect (jump/branch), and halt-on-opcode.

Parameters:
- ADDR_W, 8, program counter and memory address width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 8'hFF, fetched byte that stops fetching.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  start fetching from IDLE.
- mem_req  out  1  fetch request; combinational.
- mem_addr  out  ADDR_W  fetch address; equals pc.
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  8  instruction byte.
- stall  in  1  downstream cannot accept instr this cycle.
- redirect  in  1  load new PC, flush pipeline.
- redirect_addr  in  ADDR_W  target PC.
- instr  out  8  instruction register; drives inst_decoder input.
- instr_valid  out  1  instr holds an unconsumed instruction.
- pc  out  ADDR_W  address of the next fetch.
- halted  out  1  high while in HALTED.

Behaviour:
- Reset (asynchronous, rst_n=0) sets the following:
  - state=IDLE, pc=RESET_PC, instr=8'h00, instr_valid=0, halted=0.
  - mem_req=0 while in reset.
- States:
  - IDLE: mem_req=0. en=1 moves to FETCH on the next edge.
  - FETCH: mem_req = !(instr_valid && stall) && !redirect.
  - HALTED: mem_req=0, halted=1. Only redirect leaves this state.
- Consume rule: instr is consumed on any edge where instr_valid=1 and stall=0.
- Accept rule: fetch data is accepted on any edge where mem_req=1 and mem_ack=1. On accept:
  - instr <= mem_rdata, instr_valid <= 1, pc <= pc+1 (mod 2^ADDR_W; 8'hFF wraps to 8'h00).
- Latency: the ack edge loads instr. instr_valid is high from the following cycle.
- Throughput: with ack held high and stall=0, one instruction per cycle, no bubbles.
- Consume without accept: instr_valid <= 0; instr keeps its value.
- Consume and accept on the same edge: the new byte replaces the old; instr_valid stays 1.
- Stall with instr_valid=1:
  - mem_req=0 and no new accept.
  - instr and pc are held stable for the whole stall.
  - An ack during the stall is ignored.
- Halt: an accepted byte equal to HALT_OPCODE is loaded into instr and delivered normally.
  - pc still increments.
  - state moves to HALTED on the same edge.
- Redirect has highest priority, in any state except IDLE:
  - pc <= redirect_addr, instr_valid <= 0.
  - mem_ack in that cycle is ignored.
  - state <= FETCH, halted <= 0.
  - Redirect in IDLE is ignored.
- Simultaneous events, priority order: reset > redirect > accept > consume.
- en is sampled only in IDLE. Deasserting en later has no effect.
- Reset mid-request: all state clears immediately; mem_req drops asynchronously.

Decomposition:
- Shared package (cpu_pkg):
  - state enum: IDLE=2'd0, FETCH=2'd1, HALTED=2'd2.
  - INSTR_W=8.
  - HALT_OPCODE default value.
- Single module.
- No sub-module needed. PC incrementer and instruction register are a few lines each.

Test Plan:
- Reset then en=1, memory bytes 08,09,01,41 at addresses 0-3, ack always 1, stall=0:
  - mem_addr sequence is 0,1,2,3 on consecutive cycles.
  - instr is 08,09,01,41 on consecutive cycles, with instr_valid continuously 1.
- Stall=1 for 3 cycles while instr=09:
  - mem_req=0 and instr=09 held; pc holds 2.
  - After release, the next instruction is 01 with no skip or duplicate.
- Redirect to 8'h40 on the same edge as an ack of byte 01:
  - 01 is dropped and instr_valid=0 the next cycle.
  - mem_addr=40 the next cycle; instr=mem[40] follows.
- Fetch byte FF at address 5:
  - instr=FF is delivered with instr_valid=1, then halted=1 and pc=6.
  - mem_req stays 0 for 10 cycles.
  - Redirect to 8'h00 clears halted and fetching resumes at 0.
- pc=8'hFF fetch: the next mem_addr is 8'h00.
- Ack delayed by 2 cycles:
  - mem_req stays high and mem_addr stable.
  - instr_valid drops after the old instruction is consumed, and rises after the ack.
- rst_n pulsed low mid-stall with instr_valid=1: instr_valid=0, pc=0, mem_req=0 immediately, without waiting for clk.
